// File: rtl/alu_issue_decoder.sv
// rtl/alu_issue_decoder.sv - decode/issue stage feeding the SIMD ALU with RAW/WAW scoreboard
// Optional: ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear a hazard before issue.
module alu_issue_decoder #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [0:31] instr,
  output logic [0:4]  rf_rA_addr,
  output logic [0:4]  rf_rB_addr,
  input  logic [0:63] rf_rA_data,
  input  logic [0:63] rf_rB_data,
  input  logic        wb_valid,
  input  logic [0:4]  wb_addr,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [0:5]  ex_op_code,
  output logic [0:5]  ex_r_ins,
  output logic [0:1]  ex_ww,
  output logic [0:4]  ex_rd,
  output logic [0:63] ex_rA_val,
  output logic [0:63] ex_rB_val,
  output logic        ex_illegal
);

  localparam logic [0:5] OP_RALU  = 6'b101010;
  localparam logic [0:5] OP_LOAD  = 6'b100000;
  localparam logic [0:5] OP_STORE = 6'b100001;
  localparam logic [0:5] OP_BEZ   = 6'b100010;
  localparam logic [0:5] OP_BNZ   = 6'b100011;
  localparam logic [0:5] OP_NOP   = 6'b111100;

  localparam logic [0:5] RI_VNOP   = 6'b000000;
  localparam logic [0:5] RI_VNOT   = 6'b000100;
  localparam logic [0:5] RI_VMOV   = 6'b000101;
  localparam logic [0:5] RI_VMULEU = 6'b001000;
  localparam logic [0:5] RI_VMULOU = 6'b001001;
  localparam logic [0:5] RI_VSQEU  = 6'b010000;
  localparam logic [0:5] RI_VSQOU  = 6'b010001;
  localparam logic [0:5] RI_VSQRT  = 6'b010010;
  localparam logic [0:5] RI_MAX    = 6'b010010;

  logic                r_dec_valid;
  logic [0:31]         r_dec_instr;
  logic [NUM_REGS-1:0] r_sb;
  logic                r_ex_valid;
  logic [0:5]          r_ex_op_code;
  logic [0:5]          r_ex_r_ins;
  logic [0:1]          r_ex_ww;
  logic [0:4]          r_ex_rd;
  logic [0:63]         r_ex_rA_val;
  logic [0:63]         r_ex_rB_val;
  logic                r_ex_illegal;

  logic [0:5]          w_op;
  logic [0:4]          w_rd;
  logic [0:4]          w_ra;
  logic [0:4]          w_rb;
  logic [0:1]          w_ww;
  logic [0:5]          w_rins;
  logic                w_unused_rsvd;
  logic                w_use_a;
  logic                w_use_b;
  logic                w_writes;
  logic                w_illegal;
  logic                w_is_nop;
  logic [0:4]          w_src_a;
  logic [0:4]          w_src_b;
  logic [NUM_REGS-1:0] w_clear;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_sb_view;
  logic                w_hazard;
  logic                w_ex_free;
  logic                w_issue;

  // Bit 0 of every mask stays clear so register 0 is never tracked.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [0:4] a);
    onehot = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (a == 5'(i)) onehot[i] = 1'b1;
    end
  endfunction

  function automatic logic reg_busy(input logic [NUM_REGS-1:0] vec, input logic [0:4] a);
    reg_busy = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (a == 5'(i)) reg_busy = vec[i];
    end
  endfunction

  assign w_op          = r_dec_instr[0:5];
  assign w_rd          = r_dec_instr[6:10];
  assign w_ra          = r_dec_instr[11:15];
  assign w_rb          = r_dec_instr[16:20];
  assign w_ww          = r_dec_instr[24:25];
  assign w_rins        = r_dec_instr[26:31];
  assign w_unused_rsvd = ^r_dec_instr[21:23];

  always_comb begin
    w_use_a   = 1'b0;
    w_use_b   = 1'b0;
    w_writes  = 1'b0;
    w_illegal = 1'b0;
    w_is_nop  = 1'b0;
    w_src_a   = w_ra;
    w_src_b   = w_rb;
    case (w_op)
      OP_RALU: begin
        if ((w_rins > RI_MAX) ||
            ((w_ww == 2'b11) && ((w_rins == RI_VMULEU) || (w_rins == RI_VMULOU) ||
                                 (w_rins == RI_VSQEU)  || (w_rins == RI_VSQOU)))) begin
          w_illegal = 1'b1;
        end else begin
          w_use_a  = 1'b1;
          w_use_b  = !((w_rins == RI_VNOT)  || (w_rins == RI_VMOV)  || (w_rins == RI_VSQEU) ||
                       (w_rins == RI_VSQOU) || (w_rins == RI_VSQRT) || (w_rins == RI_VNOP));
          w_writes = (w_rins != RI_VNOP);
        end
      end
      OP_LOAD: begin
        w_use_a  = 1'b1;
        w_writes = 1'b1;
      end
      OP_STORE: begin
        w_use_a = 1'b1;
        w_use_b = 1'b1;
        w_src_b = w_rd;
      end
      OP_BEZ, OP_BNZ: begin
        w_use_a = 1'b1;
        w_src_a = w_rd;
      end
      OP_NOP:  w_is_nop  = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  assign rf_rA_addr = w_src_a;
  assign rf_rB_addr = w_src_b;

  assign w_clear = wb_valid ? onehot(wb_addr) : '0;
`ifdef ISSUE_WB_BYPASS_EN
  assign w_sb_view = r_sb & ~w_clear;
`else
  assign w_sb_view = r_sb;
`endif

  // Illegal instructions and NOPs have no use/write flags, so they never stall.
  assign w_hazard  = (w_use_a  & reg_busy(w_sb_view, w_src_a)) |
                     (w_use_b  & reg_busy(w_sb_view, w_src_b)) |
                     (w_writes & reg_busy(w_sb_view, w_rd));
  assign w_ex_free = ~r_ex_valid | ex_ready;
  assign w_issue   = r_dec_valid & ~w_hazard & w_ex_free;
  assign w_set     = (w_issue & w_writes) ? onehot(w_rd) : '0;

  assign instr_ready = ~r_dec_valid | w_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_valid <= 1'b0;
      r_dec_instr <= '0;
    end else if (instr_ready) begin
      r_dec_valid <= instr_valid;
      if (instr_valid) r_dec_instr <= instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= (r_sb & ~w_clear) | w_set;
    end
  end

  // A NOP consumes its issue slot without loading the EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_op_code <= '0;
      r_ex_r_ins   <= '0;
      r_ex_ww      <= '0;
      r_ex_rd      <= '0;
      r_ex_rA_val  <= '0;
      r_ex_rB_val  <= '0;
      r_ex_illegal <= 1'b0;
    end else if (w_issue && !w_is_nop) begin
      r_ex_valid   <= 1'b1;
      r_ex_op_code <= w_op;
      r_ex_r_ins   <= w_rins;
      r_ex_ww      <= w_ww;
      r_ex_rd      <= w_rd;
      r_ex_rA_val  <= rf_rA_data;
      r_ex_rB_val  <= rf_rB_data;
      r_ex_illegal <= w_illegal;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_op_code = r_ex_op_code;
  assign ex_r_ins   = r_ex_r_ins;
  assign ex_ww      = r_ex_ww;
  assign ex_rd      = r_ex_rd;
  assign ex_rA_val  = r_ex_rA_val;
  assign ex_rB_val  = r_ex_rB_val;
  assign ex_illegal = r_ex_illegal;

endmodule
